// File: rtl/paddle_input_ctrl_pkg.sv
// Shared game constants, paddle FSM state encoding and saturating
// position helpers used by the paddle input controller.
package paddle_input_ctrl_pkg;

    // Playfield geometry and motion defaults
    localparam int GP_DEBOUNCE_CYCLES = 250000;
    localparam int GP_SCREEN_W        = 640;
    localparam int GP_PADDLE_W        = 80;
    localparam int GP_STEP            = 4;
    localparam int GP_X_INIT          = 280;

    // Paddle motion state; value is visible on the move_state port
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE_L = 2'd1,
        ST_MOVE_R = 2'd2,
        ST_BOTH   = 2'd3
    } move_state_e;

    // Map the debounced (left, right) switch pair onto a motion state
    function automatic move_state_e state_from_switches(input logic l, input logic r);
        move_state_e st;
        case ({l, r})
            2'b00:   st = ST_IDLE;
            2'b10:   st = ST_MOVE_L;
            2'b01:   st = ST_MOVE_R;
            2'b11:   st = ST_BOTH;
            default: st = ST_IDLE;
        endcase
        return st;
    endfunction

    // x - step clamped at 0; done 11 bits wide so a small x never wraps
    function automatic logic [9:0] sat_sub(input logic [9:0] x, input int step);
        logic [10:0] xe;
        logic [10:0] se;
        logic [10:0] res;
        xe = {1'b0, x};
        se = 11'(step);
        if (xe > se) begin
            res = xe - se;
        end else begin
            res = 11'd0;
        end
        return 10'(res);
    endfunction

    // x + step clamped at max_x; 11 bits wide so the sum cannot overflow
    function automatic logic [9:0] sat_add(input logic [9:0] x, input int step, input int max_x);
        logic [10:0] sum;
        logic [10:0] me;
        sum = {1'b0, x} + 11'(step);
        me  = 11'(max_x);
        if (sum > me) begin
            sum = me;
        end else begin
            sum = sum;
        end
        return 10'(sum);
    endfunction

endpackage

// File: rtl/paddle_input_ctrl_debounce.sv
// switch_debounce: two-flop synchronizer followed by a consecutive-cycle
// debounce counter. A clean raw edge reaches db_o DEBOUNCE_CYCLES+2
// cycles later; any cycle where the synchronized input agrees with the
// debounced value restarts the count.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic db_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronize the raw switch, then count consecutive disagreeing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            if (sync2_q != db_q) begin
                if (cnt_q == CNT_LAST) begin
                    db_q  <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl: turns two raw paddle switches into a registered
// paddle x position. Switches are synchronized and debounced, the
// debounced pair selects a motion state every cycle, and the paddle moves
// one STEP per asserted frame_tick using the state held from the prior cycle.
module paddle_input_ctrl
    import paddle_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = GP_DEBOUNCE_CYCLES,
    parameter int SCREEN_W        = GP_SCREEN_W,
    parameter int PADDLE_W        = GP_PADDLE_W,
    parameter int STEP            = GP_STEP,
    parameter int X_INIT          = GP_X_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       L_swt,
    input  logic       R_swt,
    input  logic       frame_tick,
    output logic [9:0] paddle_x,
    output logic       at_left,
    output logic       at_right,
    output logic [1:0] move_state
);

    localparam int X_MAX = SCREEN_W - PADDLE_W;

    logic        l_db_s;
    logic        r_db_s;

    move_state_e state_q;
    move_state_e state_d;
    logic [9:0]  paddle_x_q;
    logic [9:0]  paddle_x_d;
    logic        at_left_q;
    logic        at_left_d;
    logic        at_right_q;
    logic        at_right_d;

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_left (
        .clk  (clk),
        .rst  (rst),
        .sw_i (L_swt),
        .db_o (l_db_s)
    );

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_right (
        .clk  (clk),
        .rst  (rst),
        .sw_i (R_swt),
        .db_o (r_db_s)
    );

    // Next motion state and next paddle position from the registered state
    always_comb begin
        state_d    = state_from_switches(l_db_s, r_db_s);
        paddle_x_d = paddle_x_q;
        case (state_q)
            ST_MOVE_L: paddle_x_d = sat_sub(paddle_x_q, STEP);
            ST_MOVE_R: paddle_x_d = sat_add(paddle_x_q, STEP, X_MAX);
            ST_IDLE:   paddle_x_d = paddle_x_q;
            ST_BOTH:   paddle_x_d = paddle_x_q;
            default:   paddle_x_d = paddle_x_q;
        endcase
        at_left_d  = (paddle_x_d == 10'd0);
        at_right_d = (paddle_x_d == 10'(X_MAX));
    end

    // State follows the debounced switches every cycle; position and edge
    // flags commit together only on frame_tick, with reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            paddle_x_q <= 10'(X_INIT);
            at_left_q  <= 1'b0;
            at_right_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (frame_tick) begin
                paddle_x_q <= paddle_x_d;
                at_left_q  <= at_left_d;
                at_right_q <= at_right_d;
            end else begin
                paddle_x_q <= paddle_x_q;
                at_left_q  <= at_left_q;
                at_right_q <= at_right_q;
            end
        end
    end

    assign paddle_x   = paddle_x_q;
    assign at_left    = at_left_q;
    assign at_right   = at_right_q;
    assign move_state = state_q;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Self-checking bench for paddle_input_ctrl. Two instances share the same
// stimulus: one with the default start position and one starting at x=2 to
// exercise left-edge saturation. A behavioural model tracks both.
module tb_paddle_input_ctrl;

    localparam int DB     = 4;
    localparam int XMAX   = 560;
    localparam int STEPPX = 4;

    logic       clk;
    logic       rst;
    logic       L_swt;
    logic       R_swt;
    logic       frame_tick;
    logic [9:0] px_a, px_b;
    logic       al_a, al_b, ar_a, ar_b;
    logic [1:0] ms_a, ms_b;

    int n_checks;
    int n_fail;

    // Behavioural model state
    int  px_m[2];
    int  xinit_m[2];
    bit  al_m[2];
    bit  ar_m[2];
    int  st_m;
    bit  raw_d1_m[2];
    bit  raw_d2_m[2];
    bit  deb_m[2];
    bit  hist_m[2][$];
    bit  valid_m;

    paddle_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut_a (
        .clk(clk), .rst(rst), .L_swt(L_swt), .R_swt(R_swt), .frame_tick(frame_tick),
        .paddle_x(px_a), .at_left(al_a), .at_right(ar_a), .move_state(ms_a)
    );

    paddle_input_ctrl #(.DEBOUNCE_CYCLES(DB), .X_INIT(2)) dut_b (
        .clk(clk), .rst(rst), .L_swt(L_swt), .R_swt(R_swt), .frame_tick(frame_tick),
        .paddle_x(px_b), .at_left(al_b), .at_right(ar_b), .move_state(ms_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_update();
        bit sw[2];
        bit all_diff;
        sw[0] = L_swt;
        sw[1] = R_swt;
        if (rst) begin
            valid_m = 1'b1;
            st_m    = 0;
            for (int k = 0; k < 2; k++) begin
                px_m[k]     = xinit_m[k];
                al_m[k]     = 1'b0;
                ar_m[k]     = 1'b0;
                raw_d1_m[k] = 1'b0;
                raw_d2_m[k] = 1'b0;
                deb_m[k]    = 1'b0;
                hist_m[k].delete();
            end
        end else begin
            if (frame_tick) begin
                for (int k = 0; k < 2; k++) begin
                    if (st_m == 1) px_m[k] = (px_m[k] - STEPPX < 0) ? 0 : px_m[k] - STEPPX;
                    if (st_m == 2) px_m[k] = (px_m[k] + STEPPX > XMAX) ? XMAX : px_m[k] + STEPPX;
                    al_m[k] = (px_m[k] == 0);
                    ar_m[k] = (px_m[k] == XMAX);
                end
            end
            // left only -> 1, right only -> 2, both -> 3, none -> 0
            st_m = (deb_m[0] ? 1 : 0) + (deb_m[1] ? 2 : 0);
            for (int k = 0; k < 2; k++) begin
                // debounced value flips once the last DB synchronized samples all disagree
                hist_m[k].push_back(raw_d2_m[k]);
                if (hist_m[k].size() > DB) void'(hist_m[k].pop_front());
                all_diff = (hist_m[k].size() == DB);
                foreach (hist_m[k][j]) if (hist_m[k][j] == deb_m[k]) all_diff = 1'b0;
                if (all_diff) deb_m[k] = ~deb_m[k];
                raw_d2_m[k] = raw_d1_m[k];
                raw_d1_m[k] = sw[k];
            end
        end
    endtask

    task automatic compare_all();
        if (valid_m) begin
            check("paddle_x_a", int'(px_a), px_m[0]);
            check("at_left_a", int'(al_a), int'(al_m[0]));
            check("at_right_a", int'(ar_a), int'(ar_m[0]));
            check("move_state_a", int'(ms_a), st_m);
            check("paddle_x_b", int'(px_b), px_m[1]);
            check("at_left_b", int'(al_b), int'(al_m[1]));
            check("at_right_b", int'(ar_b), int'(ar_m[1]));
            check("move_state_b", int'(ms_b), st_m);
        end
    endtask

    task automatic step(input logic r_v, input logic l_v, input logic rs_v, input logic t_v);
        rst        = r_v;
        L_swt      = l_v;
        R_swt      = rs_v;
        frame_tick = t_v;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int bad;
        int exp;
        logic rl, rr, rt, rx;
        n_checks   = 0;
        n_fail     = 0;
        valid_m    = 1'b0;
        xinit_m[0] = 280;
        xinit_m[1] = 2;
        rst = 1'b1; L_swt = 1'b0; R_swt = 1'b0; frame_tick = 1'b0;

        // Reset then idle
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_px", int'(px_a), 280);
        check("reset_flags", int'({al_a, ar_a}), 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            check("idle_px", int'(px_a), 280);
            check("idle_state", int'(ms_a), 0);
        end

        // Debounce latency: debounced L at edge 6, visible in state at edge 7
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 6) check("db_latency_pre", int'(ms_a), 0);
            if (i == 7) check("db_latency_post", int'(ms_a), 1);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("db_release", int'(ms_a), 0);

        // Glitch rejection: 3-cycle pulse never changes the state
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, (i < 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (ms_a != 2'd0) bad++;
        end
        check("glitch_reject", bad, 0);

        // Right movement and saturation
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("move_r_state", int'(ms_a), 2);
        for (int k = 1; k <= 200; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            exp = (280 + 4 * k > 560) ? 560 : 280 + 4 * k;
            check("move_r_px", int'(px_a), exp);
            check("move_r_at_right", int'(ar_a), (exp == 560) ? 1 : 0);
        end

        // Left underflow from x=2 (instance b)
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("b_reset_px", int'(px_b), 2);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("underflow_px", int'(px_b), 0);
        check("underflow_at_left", int'(al_b), 1);
        check("left_px_a", int'(px_a), 276);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            check("underflow_hold", int'(px_b), 0);
        end
        check("left_px_a4", int'(px_a), 264);

        // Both switches: state 3, no motion
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            check("both_state", int'(ms_a), 3);
            check("both_px", int'(px_a), 264);
        end

        // Reset on a tick edge mid-move, then debounce restarts
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        check("pre_reset_px", int'(px_a), 276);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("rst_tick_px", int'(px_a), 280);
        check("rst_tick_state", int'(ms_a), 0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            check("resume_px", int'(px_a), (i < 8) ? 280 : 284);
        end

        // Randomized traffic
        rl = 1'b0; rr = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) rl = ~rl;
            if ($urandom_range(7) == 0) rr = ~rr;
            rt = ($urandom_range(2) == 0);
            rx = ($urandom_range(199) == 0);
            step(rx, rl, rr, rt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
